// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the wait-state async-SRAM controller.
//   state_e     : controller FSM states
//   wait_cnt_w  : width of the wait counter for given write/read wait-state counts
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrSetup,
        StWrPulse,
        StWrHold,
        StRdWait,
        StRdTurn
    } state_e;

    // Counter must hold max(WR_CYCLES, RD_CYCLES) - 1; never narrower than one bit.
    function automatic int unsigned wait_cnt_w(input int unsigned wr, input int unsigned rd);
        int unsigned m;
        m = (wr > rd) ? wr : rd;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sram_io_buf.sv
// SRAM data-bus buffer: tri-state DQ driver plus read-capture register.
//   clk, rst_n : clock, synchronous active-low reset
//   drive_en   : drive wdata onto dq when high, release (Z) otherwise
//   wdata      : data to drive
//   capture    : load rdata from dq at this edge
//   rdata      : captured read data, holds until next capture
//   dq         : SRAM bidirectional data bus
module sram_io_buf #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              drive_en,
    input  logic [DATA_W-1:0] wdata,
    input  logic              capture,
    output logic [DATA_W-1:0] rdata,
    inout  wire  [DATA_W-1:0] dq
);

    assign dq = drive_en ? wdata : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (capture) begin
            rdata <= dq;
        end
    end

endmodule

// File: rtl/sram_ctrl_wait.sv
// Async-SRAM controller with programmable read/write wait states, one access in flight.
//   clk, rst_n           : clock, synchronous active-low reset
//   req_valid/req_ready  : request handshake (ready only while idle)
//   req_we/addr/wdata    : request fields, latched on accept
//   rsp_valid/rsp_rdata  : one-cycle read response pulse and captured data
//   busy                 : access in progress
//   sram_addr/dq/ce_n/we_n/oe_n : external SRAM pins (strobes registered, active low)
module sram_ctrl_wait
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned WR_CYCLES = 1,
    parameter int unsigned RD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_dq,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              sram_oe_n
);

    localparam int unsigned CntW = wait_cnt_w(WR_CYCLES, RD_CYCLES);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] wdata_q;
    logic              drive_q;
    logic              accept;
    logic              capture;

    assign accept  = req_valid & req_ready;
    // Last RD_WAIT cycle: data has been presented for RD_CYCLES cycles.
    assign capture = (state_q == StRdWait) && (cnt_q == '0);
    assign busy    = ~req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_we) begin
                        state_d = StWrSetup;
                    end else begin
                        state_d = StRdWait;
                        cnt_d   = CntW'(RD_CYCLES - 1);
                    end
                end
            end
            StWrSetup: begin
                state_d = StWrPulse;
                cnt_d   = CntW'(WR_CYCLES - 1);
            end
            StWrPulse: begin
                if (cnt_q == '0) begin
                    state_d = StWrHold;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrHold: state_d = StIdle;
            StRdWait: begin
                if (cnt_q == '0) begin
                    state_d = StRdTurn;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRdTurn: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State, request latches and strobes; strobes decode the next state so they are
    // registered yet aligned with the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sram_addr <= '0;
            wdata_q   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            sram_ce_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            drive_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                sram_addr <= req_addr;
                wdata_q   <= req_wdata;
            end
            req_ready <= (state_d == StIdle);
            rsp_valid <= (state_d == StRdTurn);
            sram_ce_n <= !(state_d inside {StWrSetup, StWrPulse, StWrHold, StRdWait});
            sram_we_n <= (state_d != StWrPulse);
            sram_oe_n <= (state_d != StRdWait);
            drive_q   <= (state_d inside {StWrSetup, StWrPulse, StWrHold});
        end
    end

    sram_io_buf #(
        .DATA_W (DATA_W)
    ) u_io_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .drive_en (drive_q),
        .wdata    (wdata_q),
        .capture  (capture),
        .rdata    (rsp_rdata),
        .dq       (sram_dq)
    );

endmodule

// File: tb/tb_sram_ctrl_wait.sv
module tb_sram_ctrl_wait;

    localparam int unsigned AW = 18;
    localparam int unsigned DW = 16;
    localparam int unsigned WR = 2;
    localparam int unsigned RD = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready, rsp_valid, busy;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] sram_addr;
    logic          sram_ce_n, sram_we_n, sram_oe_n;
    wire  [DW-1:0] sram_dq;

    int checks = 0;
    int errors = 0;

    // Behavioural SRAM: drives stored data while selected and output-enabled; drives 0
    // while deselected so any controller drive then shows up as a corrupted bus value.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          tb_en;
    logic [DW-1:0] tb_val;
    assign tb_en  = (sram_ce_n === 1'b1) || (sram_ce_n === 1'b0 && sram_oe_n === 1'b0);
    assign tb_val = (sram_ce_n === 1'b1) ? '0 : mem[sram_addr];
    assign sram_dq = tb_en ? tb_val : {DW{1'bz}};

    always @(posedge clk) begin
        if (sram_ce_n === 1'b0 && sram_we_n === 1'b0) mem[sram_addr] <= sram_dq;
    end

    // Reference: what each address should hold after the accepted writes.
    logic [DW-1:0] ref_mem [int unsigned];
    int unsigned   written[$];

    sram_ctrl_wait #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .WR_CYCLES (WR),
        .RD_CYCLES (RD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .sram_addr (sram_addr),
        .sram_dq   (sram_dq),
        .sram_ce_n (sram_ce_n),
        .sram_we_n (sram_we_n),
        .sram_oe_n (sram_oe_n)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctl();
        return {26'b0, req_ready, busy, sram_ce_n, sram_we_n, sram_oe_n, rsp_valid};
    endfunction

    // Idle pin/port picture: {ready,busy,ce_n,we_n,oe_n,rsp_valid}.
    localparam logic [5:0] IdleCtl = 6'b101110;

    // One access, starting at a negedge. Each following cycle is compared to the waveform
    // expected from the wait-state counts. abort_at > 0 asserts reset after that cycle.
    task automatic access(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input bit keep_valid, input int abort_at);
        int            n;
        int            last;
        logic [DW-1:0] exp_d;
        logic [5:0]    ec;
        logic [DW-1:0] edq;
        n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        exp_d = we ? data : ref_mem[int'(addr)];
        while (!req_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", {31'b0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        last = we ? int'(WR) + 3 : int'(RD) + 2;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (k == last) begin
                ec  = IdleCtl;
                edq = '0;
            end else if (we) begin
                ec  = {3'b010, (k >= 2 && k <= int'(WR) + 1) ? 1'b0 : 1'b1, 2'b10};
                edq = data;
            end else if (k <= int'(RD)) begin
                ec  = 6'b010100;
                edq = exp_d;
            end else begin
                ec  = 6'b011111;
                edq = '0;
            end
            check(we ? "wr_ctl" : "rd_ctl", ctl(), {26'b0, ec});
            check(we ? "wr_dq" : "rd_dq", {16'b0, sram_dq}, {16'b0, edq});
            if (!ec[3]) check("latched_addr", {14'b0, sram_addr}, {14'b0, addr});
            if (!we && k > int'(RD)) check("rd_data", {16'b0, rsp_rdata}, {16'b0, exp_d});
            if (k == 1) begin
                // Request fields move while busy; the access must not notice.
                req_addr  = AW'($urandom);
                req_wdata = DW'($urandom);
                req_we    = 1'($urandom);
                req_valid = keep_valid;
            end
            if (k == abort_at) begin
                rst_n     = 1'b0;
                req_valid = 1'b0;
                break;
            end
        end
        if (we && (abort_at == 0 || abort_at >= 2)) begin
            if (!ref_mem.exists(int'(addr))) written.push_back(int'(addr));
            ref_mem[int'(addr)] = data;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check(tag, ctl(), {26'b0, IdleCtl});
        check({tag, "_rdata"}, {16'b0, rsp_rdata}, 32'd0);
        check({tag, "_addr"}, {14'b0, sram_addr}, 32'd0);
        check({tag, "_dq"}, {16'b0, sram_dq}, 32'd0);
    endtask

    initial begin
        bit            prev_keep;
        bit            we;
        bit            keep;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", ctl(), {26'b0, IdleCtl});

        // Basic write then read.
        access(1'b1, 18'h00010, 16'hA5A5, 1'b0, 0);
        access(1'b0, 18'h00010, 16'h0000, 1'b0, 0);

        // Read then write back-to-back with valid held through busy.
        access(1'b0, 18'h00010, 16'h0000, 1'b1, 0);
        access(1'b1, 18'h00020, 16'h1234, 1'b1, 0);
        access(1'b0, 18'h00020, 16'h0000, 1'b0, 0);

        // Full-width address/data corners.
        access(1'b1, 18'h3FFFF, 16'hFFFF, 1'b0, 0);
        access(1'b0, 18'h3FFFF, 16'h0000, 1'b0, 0);
        access(1'b1, 18'h3FFFF, 16'h0000, 1'b0, 0);
        access(1'b0, 18'h3FFFF, 16'h0000, 1'b0, 0);
        access(1'b1, 18'h00000, 16'h8001, 1'b0, 0);
        access(1'b0, 18'h00000, 16'h0000, 1'b0, 0);

        // Randomized mix with random gaps or held valid.
        prev_keep = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (!prev_keep) repeat ($urandom_range(0, 2)) @(negedge clk);
            we   = (written.size() == 0) ? 1'b1 : 1'($urandom);
            keep = (i == 23) ? 1'b0 : 1'($urandom);
            if (we) a = AW'($urandom);
            else    a = AW'(written[$urandom_range(0, written.size() - 1)]);
            d = DW'($urandom);
            access(we, a, d, keep, 0);
            prev_keep = keep;
        end

        // Reset during the write pulse aborts the access at that edge.
        access(1'b1, 18'h00030, 16'hBEEF, 1'b0, 2);
        @(negedge clk);
        check_reset_state("abort");
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);

        // Controller recovers normally after the abort.
        access(1'b1, 18'h00040, 16'h5AC3, 1'b0, 0);
        access(1'b0, 18'h00040, 16'h0000, 1'b0, 0);
        access(1'b0, 18'h00020, 16'h0000, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
